// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, qualifies LOCK, then releases the system reset.
// Optional `PLL_BYPASS_FALLBACK_EN: on repeated lock timeouts, fall back to PLL bypass instead of FAULT.
`timescale 1ns/1ps
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       pll_lock,
  input  logic       fault_clr,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       locked_ok,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_cnt
`ifdef PLL_BYPASS_FALLBACK_EN
  ,
  output logic       pll_bypass
`endif
);

  localparam int unsigned RTY_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_DONE  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4,
    S_BYPASS    = 3'd5
  } state_e;

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam state_e FAIL_STATE = S_BYPASS;
`else
  localparam state_e FAIL_STATE = S_FAULT;
`endif

  state_e           r_state, w_next_state;
  logic             r_sync1, r_lock_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_aux, w_aux_nxt;
  logic [RTY_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
  logic [7:0]       r_relock, w_relock_nxt;
  logic             w_timeout;
  logic             r_pll_resetb, r_sys_rst_n, r_locked_ok, r_fault;
  logic             w_pll_resetb, w_sys_rst_n, w_locked_ok, w_fault;
`ifdef PLL_BYPASS_FALLBACK_EN
  logic             r_pll_bypass, w_pll_bypass;
`endif

  assign w_retry_inc = r_retry + RTY_W'(1);

  // State register
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) r_state <= S_PLL_RST;
    else        r_state <= w_next_state;
  end

  // Next-state and counter update; r_cnt is shared by reset hold, lock timeout and bypass release
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    w_aux_nxt    = r_aux;
    w_retry_nxt  = r_retry;
    w_relock_nxt = r_relock;
    w_timeout    = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_next_state = S_WAIT_LOCK;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_lock_s) begin
          w_next_state = S_STABLE;
          w_aux_nxt    = '0;
        end
        w_timeout = (r_cnt == TO_LAST);
      end
      S_STABLE: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_lock_s) begin
          if (r_aux == STAB_LAST) begin
            w_next_state = S_RUN;
            w_aux_nxt    = '0;
            w_retry_nxt  = '0;
          end else begin
            w_aux_nxt = r_aux + CNT_ONE;
          end
        end else begin
          w_next_state = S_WAIT_LOCK;
          w_aux_nxt    = '0;
        end
        // Completing the stable window beats a coincident timeout
        w_timeout = (r_cnt == TO_LAST) && (w_next_state != S_RUN);
      end
      S_RUN: begin
        if (r_lock_s) begin
          w_aux_nxt = '0;
        end else if (r_aux == LOSS_LAST) begin
          w_next_state = S_PLL_RST;
          w_cnt_nxt    = '0;
          w_aux_nxt    = '0;
          if (r_relock != 8'hFF) w_relock_nxt = r_relock + 8'd1;
        end else begin
          w_aux_nxt = r_aux + CNT_ONE;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          w_next_state = S_PLL_RST;
          w_cnt_nxt    = '0;
          w_retry_nxt  = '0;
        end
      end
`ifdef PLL_BYPASS_FALLBACK_EN
      S_BYPASS: begin
        if (fault_clr) begin
          w_next_state = S_PLL_RST;
          w_cnt_nxt    = '0;
          w_retry_nxt  = '0;
        end else if (r_cnt != RST_DONE) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
`endif
      default: begin
        w_next_state = S_PLL_RST;
        w_cnt_nxt    = '0;
      end
    endcase
    if (w_timeout) begin
      w_retry_nxt  = w_retry_inc;
      w_cnt_nxt    = '0;
      w_aux_nxt    = '0;
      w_next_state = (w_retry_inc == RTY_MAX) ? FAIL_STATE : S_PLL_RST;
    end
  end

  // Output decode from the upcoming state so registered outputs line up with the state output
  always_comb begin
    w_pll_resetb = 1'b0;
    w_sys_rst_n  = 1'b0;
    w_locked_ok  = 1'b0;
    w_fault      = 1'b0;
`ifdef PLL_BYPASS_FALLBACK_EN
    w_pll_bypass = 1'b0;
`endif
    case (w_next_state)
      S_WAIT_LOCK, S_STABLE: w_pll_resetb = 1'b1;
      S_RUN: begin
        w_pll_resetb = 1'b1;
        w_sys_rst_n  = 1'b1;
        w_locked_ok  = 1'b1;
      end
      S_FAULT: w_fault = 1'b1;
`ifdef PLL_BYPASS_FALLBACK_EN
      S_BYPASS: begin
        w_pll_bypass = 1'b1;
        w_pll_resetb = 1'b1;
        w_fault      = 1'b1;
        w_sys_rst_n  = (w_cnt_nxt == RST_DONE);
      end
`endif
      default: ;
    endcase
  end

  // Datapath, lock synchroniser and output registers
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1      <= 1'b0;
      r_lock_s     <= 1'b0;
      r_cnt        <= '0;
      r_aux        <= '0;
      r_retry      <= '0;
      r_relock     <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_rst_n  <= 1'b0;
      r_locked_ok  <= 1'b0;
      r_fault      <= 1'b0;
`ifdef PLL_BYPASS_FALLBACK_EN
      r_pll_bypass <= 1'b0;
`endif
    end else begin
      r_sync1      <= pll_lock;
      r_lock_s     <= r_sync1;
      r_cnt        <= w_cnt_nxt;
      r_aux        <= w_aux_nxt;
      r_retry      <= w_retry_nxt;
      r_relock     <= w_relock_nxt;
      r_pll_resetb <= w_pll_resetb;
      r_sys_rst_n  <= w_sys_rst_n;
      r_locked_ok  <= w_locked_ok;
      r_fault      <= w_fault;
`ifdef PLL_BYPASS_FALLBACK_EN
      r_pll_bypass <= w_pll_bypass;
`endif
    end
  end

  assign pll_resetb = r_pll_resetb;
  assign sys_rst_n  = r_sys_rst_n;
  assign locked_ok  = r_locked_ok;
  assign fault      = r_fault;
  assign state      = r_state;
  assign relock_cnt = r_relock;
`ifdef PLL_BYPASS_FALLBACK_EN
  assign pll_bypass = r_pll_bypass;
`endif

endmodule
